// File: rtl/pipeline_pkg.sv
// Shared types for the hazard/forwarding slice: forward-select encoding, the
// per-stage shadow record and the debug snapshot of the unit's state.
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_ALU = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } shadow_t;

   typedef struct packed {
      shadow_t ex;
      shadow_t mem;
      shadow_t wb;
      logic    flush_pending;
   } hfu_dbg_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the core pipeline (master) and the hazard/forwarding unit (slave).
interface hazard_forward_unit_if
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  ex_branch_taken;
   // mem_ready is the data memory's completion flag: while it is low every
   // pipeline register holds, and a taken branch seen then is remembered and
   // applied on the first cycle it is high again.
   logic                  mem_ready;

   logic [1:0]            forward_a;
   logic [1:0]            forward_b;
   logic                  stall_if_id;
   logic                  bubble_id_ex;
   logic                  flush_if_id;
   logic                  freeze;
   logic [CNT_W-1:0]      stall_count;
   logic [CNT_W-1:0]      flush_count;
   hfu_dbg_t              dbg;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, ex_branch_taken, mem_ready,
      input  forward_a, forward_b, stall_if_id, bubble_id_ex, flush_if_id,
             freeze, stall_count, flush_count, dbg
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, ex_branch_taken, mem_ready,
      output forward_a, forward_b, stall_if_id, bubble_id_ex, flush_if_id,
             freeze, stall_count, flush_count, dbg
   );

endinterface

// File: rtl/fwd_compare.sv
// Per-operand forwarding priority: youngest non-load producer in EX wins,
// then any producer in MEM, otherwise the register file.
module fwd_compare
   import pipeline_pkg::*;
(
   input  logic                  use_rs,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  mem_valid,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   output fwd_sel_e              sel
);

   always_comb begin
      sel = FWD_REG;
      if (use_rs && rs != '0) begin
         // A load in EX has no ALU result yet; the load-use stall covers it.
         if (ex_valid && ex_reg_write && !ex_mem_read && ex_rd == rs) begin
            sel = FWD_ALU;
         end else if (mem_valid && mem_reg_write && mem_rd == rs) begin
            sel = FWD_MEM;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select, load-use stall, branch flush and memory freeze control
// for the 5-stage core. Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_forward_unit
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   hazard_forward_unit_if.slave bus
);

   shadow_t  ex_q, mem_q, wb_q;
   shadow_t  id_info;
   fwd_sel_e fwd_a_d, fwd_b_d;
   fwd_sel_e fwd_a_q, fwd_b_q;
   logic     flush_pending_q;
   logic     advance;
   logic     load_use;
   logic     flush_apply;
   logic     stall;
   logic     bubble;

   assign advance = !rst && bus.mem_ready;

   assign id_info = '{valid:     1'b1,
                      rd:        bus.id_rd,
                      reg_write: bus.id_reg_write,
                      mem_read:  bus.id_mem_read};

   fwd_compare u_fwd_a (
      .use_rs       (bus.id_use_rs1),
      .rs           (bus.id_rs1),
      .ex_valid     (ex_q.valid),
      .ex_rd        (ex_q.rd),
      .ex_reg_write (ex_q.reg_write),
      .ex_mem_read  (ex_q.mem_read),
      .mem_valid    (mem_q.valid),
      .mem_rd       (mem_q.rd),
      .mem_reg_write(mem_q.reg_write),
      .sel          (fwd_a_d)
   );

   fwd_compare u_fwd_b (
      .use_rs       (bus.id_use_rs2),
      .rs           (bus.id_rs2),
      .ex_valid     (ex_q.valid),
      .ex_rd        (ex_q.rd),
      .ex_reg_write (ex_q.reg_write),
      .ex_mem_read  (ex_q.mem_read),
      .mem_valid    (mem_q.valid),
      .mem_rd       (mem_q.rd),
      .mem_reg_write(mem_q.reg_write),
      .sel          (fwd_b_d)
   );

   always_comb begin
      load_use = 1'b0;
      if (bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != '0) begin
         if (bus.id_use_rs1 && bus.id_rs1 == ex_q.rd) load_use = 1'b1;
         if (bus.id_use_rs2 && bus.id_rs2 == ex_q.rd) load_use = 1'b1;
      end
   end

   // A flush wins over a load-use stall: the stalled instruction is discarded anyway.
   assign flush_apply = advance && (bus.ex_branch_taken || flush_pending_q);
   assign stall       = advance && load_use && !flush_apply;
   assign bubble      = advance && (load_use || flush_apply);

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q            <= '0;
         mem_q           <= '0;
         wb_q            <= '0;
         fwd_a_q         <= FWD_REG;
         fwd_b_q         <= FWD_REG;
         flush_pending_q <= 1'b0;
      end else if (advance) begin
         wb_q            <= mem_q;
         mem_q           <= ex_q;
         ex_q            <= (bus.id_valid && !bubble) ? id_info : '0;
         fwd_a_q         <= fwd_a_d;
         fwd_b_q         <= fwd_b_d;
         flush_pending_q <= 1'b0;
      end else if (bus.ex_branch_taken) begin
         flush_pending_q <= 1'b1;
      end
   end

   assign bus.forward_a    = fwd_a_q;
   assign bus.forward_b    = fwd_b_q;
   assign bus.stall_if_id  = stall;
   assign bus.bubble_id_ex = bubble;
   assign bus.flush_if_id  = flush_apply;
   assign bus.freeze       = !rst && !bus.mem_ready;
   assign bus.dbg          = '{ex: ex_q, mem: mem_q, wb: wb_q,
                               flush_pending: flush_pending_q};

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && stall_cnt_q != '1)       stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_apply && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`else
   assign bus.stall_count = '0;
   assign bus.flush_count = '0;
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Decides, per operand, which source the EX-stage forwarding muxes select.
- Encodings: 00 = register file data, 10 = ALU result from EX/MEM, 01 = memory/writeback data from MEM/WB.
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Generates load-use stall, branch flush and data-memory freeze control for the 5-stage RISC-V core. Sits directly upstream of the EX forwarding muxes.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_W  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_ready  in  1  data memory done; 0 freezes the whole pipeline
- forward_a  out  2  mux control, operand A of EX instruction
- forward_b  out  2  mux control, operand B of EX instruction
- stall_if_id  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  clear IF/ID
- freeze  out  1  hold all pipeline registers (= rst ? 0 : !mem_ready)
- stall_count  out  CNT_W  load-use stalls (optional)
- flush_count  out  CNT_W  flushes (optional)

Behaviour:
- Shadow stages EX, MEM, WB: {valid, rd, reg_write, mem_read}. Reset: all valid=0, rd=0.
- Registered outputs forward_a/forward_b reset to 00.
- During rst: stall_if_id, bubble_id_ex, flush_if_id and freeze all 0.
- Advance occurs when !freeze:
  - WB<=MEM, MEM<=EX.
  - EX<=ID info if id_valid and no bubble, else invalid.
- Forward select, computed in ID and registered into forward_a/b on advance, so it is aligned with the instruction in EX; per operand:
  - Operand not used, or rs==0: 00.
  - Else rs matches current EX shadow (valid, reg_write, rd==rs, not load): 10.
  - Else rs matches current MEM shadow (valid, reg_write, rd==rs): 01.
  - Else 00.
  - The 10 match takes priority over 01 (youngest producer wins).
- Load-use (combinational):
  - Trigger: EX shadow valid load, rd!=0, rd matches a used ID source.
  - Response: stall_if_id=1, bubble_id_ex=1 for exactly one cycle.
  - After the bubble the load is in MEM, so the next evaluation yields 01.
- Flush (combinational):
  - ex_branch_taken with !freeze: flush_if_id=1, bubble_id_ex=1, stall_if_id=0.
  - Flush overrides load-use.
- Pending flush:
  - ex_branch_taken while freeze sets a flush_pending register.
  - The flush is applied on the first cycle with mem_ready=1; flush_pending then clears.
  - Reset clears flush_pending.
- Freeze: all shadow state and forward outputs hold; stall/bubble/flush outputs forced 0.
- Reset mid-operation: next cycle all shadows invalid; no stale forwarding.
- The forwarding select is a single cycle of comparator logic; latency is 1 cycle from ID evaluation to forward output.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments once per load-use stall cycle.
  - flush_count increments once per applied flush.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared package pipeline_pkg:
  - fwd_sel_e enum: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_ALU=2'b10.
  - Shadow-stage struct.
  - REG_ADDR_W constant.
- One sub-module, fwd_compare: combinational per-operand priority compare, instantiated twice (A, B).

Test Plan:
- add x5 in EX, ID reads rs1=x5 -> next cycle forward_a=10, forward_b=00.
- x5 written by EX and MEM shadows, ID rs2=x5 -> forward_b=10 (priority).
- lw x7 in EX, ID uses rs1=x7 -> stall_if_id=1 and bubble_id_ex=1 for 1 cycle; then forward_a=01.
- ID rd/rs=x0 with a writer of x0 in EX -> forward stays 00, no stall.
- Load-use and ex_branch_taken same cycle -> flush_if_id=1, stall_if_id=0.
- ex_branch_taken while mem_ready=0 for 3 cycles -> outputs frozen; flush_if_id=1 on the cycle mem_ready returns.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls and 2 flushes -> stall_count=3, flush_count=2; rst -> both 0.
